// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//
// N-channel push-button conditioner. Each channel has its own input
// synchroniser, saturating hysteresis counter, stable level register and
// registered one-cycle press/release pulses. All channels share one clock and
// are otherwise fully independent.
//
// Optional feature (compile-time macro MULTI_DEBOUNCER_AUTOREPEAT_EN):
//   when defined, each channel gets a hold-to-auto-repeat timer that emits
//   btn_repeat pulses REPEAT_DELAY cycles after the press pulse and then every
//   REPEAT_PERIOD cycles while the level stays high. When undefined, no timer
//   logic exists and btn_repeat is tied to 0. The port list is identical.
//
// Ports:
//   clk          in   1     system clock, all logic on posedge
//   rst_n        in   1     asynchronous active-low reset
//   btn_raw      in   N_CH  raw asynchronous button levels
//   btn_level    out  N_CH  debounced stable level
//   btn_press    out  N_CH  one-cycle pulse on debounced rising edge
//   btn_release  out  N_CH  one-cycle pulse on debounced falling edge
//   btn_repeat   out  N_CH  one-cycle auto-repeat pulse (0 without feature)
//   any_press    out  1     registered OR of the press conditions
//
// No handshakes: every output is a registered level or pulse, valid every
// cycle. No FSM; per-channel state is the counter plus the level flops.
// -----------------------------------------------------------------------------
module multi_debouncer #(
    parameter int N_CH          = 4,
    parameter int COUNTER_BITS  = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat,
    output logic            any_press
);

    localparam logic [COUNTER_BITS-1:0] CMAX    = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);

    // Elaboration-time guard on the legal parameter ranges.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("multi_debouncer: illegal SYNC_STAGES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic [N_CH-1:0] r_level;
    logic [N_CH-1:0] r_level_d;
    logic [N_CH-1:0] r_press;
    logic [N_CH-1:0] r_release;
    logic            r_any_press;

    logic [N_CH-1:0] w_level_nxt;
    logic [N_CH-1:0] w_press_cond;
    logic [N_CH-1:0] w_release_cond;

    // -------------------------------------------------------------------------
    // Per-channel synchroniser and saturating hysteresis counter
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0]  r_sync;
        logic [COUNTER_BITS-1:0] r_cnt;
        logic [COUNTER_BITS-1:0] w_cnt_nxt;
        logic                    w_s;

        assign w_s = r_sync[SYNC_STAGES-1];

        // Counter moves one step toward the synchronised sample and sticks at
        // either rail instead of wrapping.
        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_s && (r_cnt != CMAX)) begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end else if (!w_s && (r_cnt != '0)) begin
                w_cnt_nxt = r_cnt - CNT_ONE;
            end
        end

        // Level only changes when the current count sits on a rail; anywhere
        // in between it holds, which gives the hysteresis band.
        assign w_level_nxt[i] = (r_cnt == CMAX) ? 1'b1 :
                                (r_cnt == '0)   ? 1'b0 : r_level[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
                r_cnt  <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw[i]};
                r_cnt  <= w_cnt_nxt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Level, delayed level and edge pulses
    // -------------------------------------------------------------------------
    // Edges are taken between the level and its one-cycle delayed copy; both
    // reset to 0 so leaving reset can never produce a pulse.
    assign w_press_cond   =  r_level & ~r_level_d;
    assign w_release_cond = ~r_level &  r_level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level     <= '0;
            r_level_d   <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_any_press <= 1'b0;
        end else begin
            r_level     <= w_level_nxt;
            r_level_d   <= r_level;
            r_press     <= w_press_cond;
            r_release   <= w_release_cond;
            r_any_press <= |w_press_cond;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign any_press   = r_any_press;

    // -------------------------------------------------------------------------
    // Auto-repeat
    // -------------------------------------------------------------------------
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(RPT_MAX) + 1;
    localparam logic [TMR_W-1:0] C_DELAY  = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] C_PERIOD = TMR_W'(REPEAT_PERIOD);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_rpt
        logic [TMR_W-1:0] r_tmr;
        logic             r_phase;   // 0: waiting for first repeat, 1: periodic
        logic             r_rpt;
        logic             w_fire;

        // The timer counts level-high cycles. The press pulse edge is the
        // first one where it leaves 0, so a match on C_DELAY lands exactly
        // REPEAT_DELAY cycles after the press cycle. After each repeat it
        // restarts at 1 so the next match is REPEAT_PERIOD cycles later.
        assign w_fire = (r_tmr == (r_phase ? C_PERIOD : C_DELAY));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tmr   <= '0;
                r_phase <= 1'b0;
                r_rpt   <= 1'b0;
            end else if (!r_level[i]) begin
                r_tmr   <= '0;
                r_phase <= 1'b0;
                r_rpt   <= 1'b0;
            end else if (w_fire) begin
                r_tmr   <= TMR_ONE;
                r_phase <= 1'b1;
                // Suppress a repeat that would coincide with the level falling.
                r_rpt   <= w_level_nxt[i];
            end else begin
                r_tmr   <= r_tmr + TMR_ONE;
                r_rpt   <= 1'b0;
            end
        end

        assign btn_repeat[i] = r_rpt;
    end
`else
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
//
// Directed bench for multi_debouncer with N_CH=4, COUNTER_BITS=4,
// SYNC_STAGES=2, REPEAT_DELAY=5, REPEAT_PERIOD=3. Expected repeat behaviour
// follows MULTI_DEBOUNCER_AUTOREPEAT_EN as seen by this compilation.
//
// Timing convention: inputs change 1 ns after a rising edge; "edge 0" is the
// first rising edge that samples a new input value; outputs are read 1 ns
// after each edge.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;

    localparam int N_CH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_repeat;
    logic            any_press;

    int n_checks = 0;
    int n_errors = 0;

    multi_debouncer #(
        .N_CH         (N_CH),
        .COUNTER_BITS (4),
        .SYNC_STAGES  (2),
        .REPEAT_DELAY (5),
        .REPEAT_PERIOD(3)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .any_press  (any_press)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = '0;
        repeat (3) step();
        n_checks++;
        if (btn_level !== 4'b0000) begin
            n_errors++; $display("FAIL reset_level: got %b expected 0000", btn_level);
        end
        n_checks++;
        if (btn_press !== 4'b0000 || btn_release !== 4'b0000) begin
            n_errors++; $display("FAIL reset_pulses: got press %b release %b expected 0000", btn_press, btn_release);
        end
        n_checks++;
        if (btn_repeat !== 4'b0000 || any_press !== 1'b0) begin
            n_errors++; $display("FAIL reset_repeat_any: got repeat %b any %b expected 0000 0", btn_repeat, any_press);
        end
        #3 rst_n = 1'b1;
        repeat (5) step();
        n_checks++;
        if (btn_level !== 4'b0000 || btn_press !== 4'b0000 || any_press !== 1'b0) begin
            n_errors++; $display("FAIL reset_release_no_pulse: got level %b press %b any %b expected 0", btn_level, btn_press, any_press);
        end
    endtask

    task automatic test_clean_press();
        logic [N_CH-1:0] exp_v;
        btn_raw = 4'b0001;
        for (int e = 0; e <= 22; e++) begin
            step();
            exp_v = (e == 18) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (btn_press !== exp_v) begin
                n_errors++; $display("FAIL clean_press e=%0d: got %b expected %b", e, btn_press, exp_v);
            end
            n_checks++;
            if (any_press !== (e == 18)) begin
                n_errors++; $display("FAIL clean_any e=%0d: got %b expected %b", e, any_press, (e == 18));
            end
            if (e == 15) begin
                n_checks++;
                if (btn_level !== 4'b0000) begin
                    n_errors++; $display("FAIL clean_level_early: got %b expected 0000", btn_level);
                end
            end
            if (e >= 17) begin
                n_checks++;
                if (btn_level !== 4'b0001) begin
                    n_errors++; $display("FAIL clean_level e=%0d: got %b expected 0001", e, btn_level);
                end
            end
        end
        btn_raw = 4'b0000;
        for (int e = 0; e <= 20; e++) begin
            step();
            exp_v = (e == 18) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (btn_release !== exp_v) begin
                n_errors++; $display("FAIL clean_release e=%0d: got %b expected %b", e, btn_release, exp_v);
            end
        end
        n_checks++;
        if (btn_level !== 4'b0000) begin
            n_errors++; $display("FAIL clean_level_after_release: got %b expected 0000", btn_level);
        end
        repeat (10) step();
    endtask

    task automatic test_bounce();
        logic [N_CH-1:0] exp_v;
        // One low sample (edge 5) inside a high run costs two cycles.
        btn_raw = 4'b0010;
        for (int e = 0; e <= 22; e++) begin
            step();
            if (e == 4) btn_raw[1] = 1'b0;
            if (e == 5) btn_raw[1] = 1'b1;
            exp_v = (e == 20) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (btn_press !== exp_v) begin
                n_errors++; $display("FAIL bounce_press e=%0d: got %b expected %b", e, btn_press, exp_v);
            end
        end
        btn_raw = 4'b0000;
        repeat (40) step();
        // Three-sample high glitch from idle: the counter never reaches the rail.
        btn_raw = 4'b0010;
        for (int e = 0; e <= 25; e++) begin
            step();
            if (e == 2) btn_raw = 4'b0000;
            n_checks++;
            if (btn_press !== 4'b0000 || btn_level !== 4'b0000) begin
                n_errors++; $display("FAIL glitch e=%0d: got press %b level %b expected 0000 0000", e, btn_press, btn_level);
            end
        end
        repeat (5) step();
    endtask

    task automatic test_release_simul();
        logic [N_CH-1:0] exp_v;
        btn_raw = 4'b1100;
        for (int e = 0; e <= 20; e++) begin
            step();
            exp_v = (e == 18) ? 4'b1100 : 4'b0000;
            n_checks++;
            if (btn_press !== exp_v) begin
                n_errors++; $display("FAIL simul_press e=%0d: got %b expected %b", e, btn_press, exp_v);
            end
        end
        repeat (5) step();
        n_checks++;
        if (btn_level !== 4'b1100) begin
            n_errors++; $display("FAIL simul_level_high: got %b expected 1100", btn_level);
        end
        btn_raw = 4'b0000;
        for (int e = 0; e <= 20; e++) begin
            step();
            exp_v = (e == 18) ? 4'b1100 : 4'b0000;
            n_checks++;
            if (btn_release !== exp_v) begin
                n_errors++; $display("FAIL simul_release e=%0d: got %b expected %b", e, btn_release, exp_v);
            end
            n_checks++;
            if (any_press !== 1'b0 || btn_press !== 4'b0000) begin
                n_errors++; $display("FAIL simul_no_press e=%0d: got any %b press %b expected 0 0000", e, any_press, btn_press);
            end
        end
        repeat (10) step();
    endtask

    task automatic test_async_reset();
        logic [N_CH-1:0] exp_v;
        btn_raw = 4'b1000;
        repeat (20) step();
        // Channel 0 starts counting; after edge 10 its counter holds 9.
        btn_raw = 4'b1001;
        for (int e = 0; e <= 10; e++) step();
        n_checks++;
        if (btn_level !== 4'b1000) begin
            n_errors++; $display("FAIL areset_pre_level: got %b expected 1000", btn_level);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (btn_level !== 4'b0000) begin
            n_errors++; $display("FAIL areset_level: got %b expected 0000", btn_level);
        end
        n_checks++;
        if (btn_press !== 4'b0000 || btn_release !== 4'b0000 || btn_repeat !== 4'b0000 || any_press !== 1'b0) begin
            n_errors++; $display("FAIL areset_pulses: got press %b release %b repeat %b any %b expected 0", btn_press, btn_release, btn_repeat, any_press);
        end
        #2 rst_n = 1'b1;
        // Both held channels restart from zero and press together.
        for (int e = 0; e <= 20; e++) begin
            step();
            exp_v = (e == 18) ? 4'b1001 : 4'b0000;
            n_checks++;
            if (btn_press !== exp_v) begin
                n_errors++; $display("FAIL areset_press e=%0d: got %b expected %b", e, btn_press, exp_v);
            end
            n_checks++;
            if (any_press !== (e == 18)) begin
                n_errors++; $display("FAIL areset_any e=%0d: got %b expected %b", e, any_press, (e == 18));
            end
        end
        btn_raw = 4'b0000;
        repeat (40) step();
    endtask

    task automatic test_autorepeat();
        logic [N_CH-1:0] exp_p;
        logic [N_CH-1:0] exp_r;
        logic [N_CH-1:0] exp_rep;
        // Press at edge 18; raw low sampled from edge 24, so the level falls
        // after edge 41 and the release pulse is at edge 42. The repeat that
        // would land on edge 41 must be suppressed.
        btn_raw = 4'b0001;
        for (int e = 0; e <= 50; e++) begin
            step();
            if (e == 23) btn_raw = 4'b0000;
            exp_p = (e == 18) ? 4'b0001 : 4'b0000;
            exp_r = (e == 42) ? 4'b0001 : 4'b0000;
            exp_rep = 4'b0000;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
            if (e >= 23 && e <= 38 && ((e - 23) % 3 == 0)) exp_rep = 4'b0001;
`endif
            n_checks++;
            if (btn_repeat !== exp_rep) begin
                n_errors++; $display("FAIL repeat e=%0d: got %b expected %b", e, btn_repeat, exp_rep);
            end
            n_checks++;
            if (btn_press !== exp_p) begin
                n_errors++; $display("FAIL repeat_press e=%0d: got %b expected %b", e, btn_press, exp_p);
            end
            n_checks++;
            if (btn_release !== exp_r) begin
                n_errors++; $display("FAIL repeat_release e=%0d: got %b expected %b", e, btn_release, exp_r);
            end
        end
        repeat (5) step();
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_simul();
        test_async_reset();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
